// File: rtl/tsqr_drain_pkg.sv
// Shared constants, FSM state type and tile index helper for the R drain.
// Dense tile sizing applies when TSQR_R_ZERO_FILL_EN is defined.
package tsqr_drain_pkg;

    localparam int BW     = 64;
    localparam int COL_NO = 2;
    localparam int ELEMS  = COL_NO * (COL_NO + 1) / 2;
    localparam int DENSE  = COL_NO * COL_NO;

`ifdef TSQR_R_ZERO_FILL_EN
    localparam int TILE_N = DENSE;
`else
    localparam int TILE_N = ELEMS;
`endif

    localparam int IDX_W = (DENSE > 2) ? $clog2(DENSE) : 1;
    localparam int RC_W  = (COL_NO > 1) ? $clog2(COL_NO) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_e;

    typedef struct packed {
        logic [RC_W-1:0] row;
        logic [RC_W-1:0] col;
    } rc_t;

    function automatic rc_t idx_to_rc(input logic [IDX_W-1:0] idx);
        rc_t rc;
        rc.row = RC_W'(int'(idx) / COL_NO);
        rc.col = RC_W'(int'(idx) % COL_NO);
        return rc;
    endfunction

endpackage

// File: rtl/tsqr_drain_fifo.sv
// First-word-fall-through buffer for the R stream.
// Head word is visible whenever the FIFO is non-empty; no bypass path.
module tsqr_drain_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr_en;
    logic         rd_en;

    always_comb begin
        full  = (wr_q[AW] != rd_q[AW]) &&
                (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty = (wr_q == rd_q);
        rd_en = pop && !empty;
        // A pop in the same cycle frees the slot being written.
        wr_en = push && (!full || rd_en);
        drop  = push && full && !rd_en;
        wr_d  = wr_q + (AW+1)'(wr_en);
        rd_d  = rd_q + (AW+1)'(rd_en);
        dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/tsqr_r_drain.sv
// R-factor drain: buffers the core's R stream and re-emits it framed per tile.
// Define TSQR_R_ZERO_FILL_EN to emit dense tiles with zeros below the diagonal.
module tsqr_r_drain
    import tsqr_drain_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_drain_en,
    input  logic [CNT_W-1:0] io_mx_no,
    input  logic             io_r_vld,
    input  logic [BW-1:0]    io_r_0,
    output logic             io_out_vld,
    input  logic             io_out_rdy,
    output logic [BW-1:0]    io_out_data,
    output logic             io_out_last,
    output logic             io_drain_fi,
    output logic             io_ovf
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] in_tot_q, in_tot_d;
    logic [CNT_W-1:0] out_tot_q, out_tot_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] tile_q, tile_d;
    logic [IDX_W-1:0] e_q, e_d;
    logic             ovf_q, ovf_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic [BW-1:0]    fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic             zpos;
    logic             adv;
`ifdef TSQR_R_ZERO_FILL_EN
    rc_t              rc;
`endif

    tsqr_drain_fifo #(
        .W     (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (io_r_0),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    always_comb begin
        state_d   = state_q;
        in_tot_d  = in_tot_q;
        out_tot_d = out_tot_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        tile_d    = tile_q;
        e_d       = e_q;
        ovf_d     = ovf_q || (fifo_full && fifo_drop);
        zpos      = 1'b0;
`ifdef TSQR_R_ZERO_FILL_EN
        rc   = idx_to_rc(e_q);
        zpos = ((state_q == RUN) || (state_q == FLUSH)) &&
               (rc.row > rc.col);
`endif
        io_out_vld  = zpos || !fifo_empty;
        io_out_data = zpos ? '0 : fifo_dout;
        io_out_last = io_out_vld && (e_q == IDX_W'(TILE_N - 1));
        io_drain_fi = (state_q == DONE);
        io_ovf      = ovf_q;
        adv         = io_out_vld && io_out_rdy;
        fifo_pop    = adv && !zpos;
        fifo_push   = io_r_vld && (state_q == RUN);

        if (adv) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (io_out_last) begin
                e_d    = '0;
                tile_d = tile_q + 1'b1;
            end else begin
                e_d = e_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (io_drain_en) begin
                    if (io_mx_no != '0) begin
                        state_d   = RUN;
                        in_tot_d  = io_mx_no * CNT_W'(ELEMS);
                        out_tot_d = io_mx_no * CNT_W'(TILE_N);
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        tile_d    = '0;
                        e_d       = '0;
                        ovf_d     = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // Dropped words still count so the run always terminates.
                if (fifo_push) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_d == in_tot_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // After an overflow the output count can never reach total.
                if (fifo_empty && !zpos &&
                    ((out_cnt_q == out_tot_q) || ovf_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!io_drain_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            in_tot_q  <= '0;
            out_tot_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            tile_q    <= '0;
            e_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_tot_q  <= in_tot_d;
            out_tot_q <= out_tot_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            tile_q    <= tile_d;
            e_q       <= e_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_tsqr_r_drain.sv
// Directed bench for tsqr_r_drain with a queue scoreboard on the output.
// Expectations follow the dense layout when TSQR_R_ZERO_FILL_EN is defined.
module tb_tsqr_r_drain;
    import tsqr_drain_pkg::*;

`ifdef TSQR_R_ZERO_FILL_EN
    localparam int TB_TILE = COL_NO * COL_NO;
`else
    localparam int TB_TILE = COL_NO * (COL_NO + 1) / 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        drain_en = 1'b0;
    logic [31:0] mx_no = '0;
    logic        r_vld = 1'b0;
    logic [63:0] r_0 = '0;
    logic        out_rdy = 1'b0;
    logic        out_vld;
    logic [63:0] out_data;
    logic        out_last;
    logic        drain_fi;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int exp_idx = 0;
    logic [64:0] expq [$];
    logic [63:0] w [12];

    tsqr_r_drain dut (
        .clock       (clock),
        .reset       (reset),
        .io_drain_en (drain_en),
        .io_mx_no    (mx_no),
        .io_r_vld    (r_vld),
        .io_r_0      (r_0),
        .io_out_vld  (out_vld),
        .io_out_rdy  (out_rdy),
        .io_out_data (out_data),
        .io_out_last (out_last),
        .io_drain_fi (drain_fi),
        .io_ovf      (ovf)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [64:0] got,
                       input logic [64:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit below_diag(input int i);
        int p;
        p = i % (COL_NO * COL_NO);
        return (p / COL_NO) > (p % COL_NO);
    endfunction

    function automatic logic is_last(input int i);
        return (i % TB_TILE) == (TB_TILE - 1);
    endfunction

    task automatic exp_push(input logic [63:0] d);
`ifdef TSQR_R_ZERO_FILL_EN
        while (below_diag(exp_idx)) begin
            expq.push_back({is_last(exp_idx), 64'h0});
            exp_idx++;
        end
`endif
        expq.push_back({is_last(exp_idx), d});
        exp_idx++;
    endtask

    task automatic exp_tail();
`ifdef TSQR_R_ZERO_FILL_EN
        while (below_diag(exp_idx)) begin
            expq.push_back({is_last(exp_idx), 64'h0});
            exp_idx++;
        end
`endif
    endtask

    task automatic start(input int n);
        @(posedge clock);
        #1;
        drain_en = 1'b1;
        mx_no    = n;
        exp_idx  = 0;
    endtask

    task automatic send(input logic [63:0] d, input bit keep);
        @(posedge clock);
        #1;
        r_vld = 1'b1;
        r_0   = d;
        if (keep) exp_push(d);
    endtask

    task automatic end_send();
        @(posedge clock);
        #1;
        r_vld = 1'b0;
        r_0   = '0;
    endtask

    task automatic wait_fi(input string tag);
        int n;
        n = 0;
        while (drain_fi !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 65'(drain_fi), 65'd1);
    endtask

    task automatic back_to_idle(input string tag);
        @(posedge clock);
        #1;
        drain_en = 1'b0;
        repeat (2) @(negedge clock);
        chk(tag, 65'(drain_fi), 65'd0);
    endtask

    // Output monitor: every accepted word must match the scoreboard head.
    always @(negedge clock) begin
        if (reset && out_vld && out_rdy) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word observed=%0h expected=none",
                       out_data);
            end
            if (expq.size() != 0) begin
                chk("out_word", {out_last, out_data}, expq.pop_front());
            end
            last_pop_cyc = cyc;
        end
    end

    initial begin
        w[0]  = 64'h3FF0_0000_0000_0000;
        w[1]  = 64'h4000_0000_0000_0000;
        w[2]  = 64'h4008_0000_0000_0000;
        w[3]  = 64'h4010_0000_0000_0000;
        w[4]  = 64'h4014_0000_0000_0000;
        w[5]  = 64'h4018_0000_0000_0000;
        w[6]  = 64'h401C_0000_0000_0000;
        w[7]  = 64'h4020_0000_0000_0000;
        w[8]  = 64'h4022_0000_0000_0000;
        w[9]  = 64'h4024_0000_0000_0000;
        w[10] = 64'h4026_0000_0000_0000;
        w[11] = 64'h4028_0000_0000_0000;

        // Reset state
        repeat (2) @(posedge clock);
        #2;
        chk("rst_vld", 65'(out_vld), 65'd0);
        chk("rst_data", 65'(out_data), 65'd0);
        chk("rst_last", 65'(out_last), 65'd0);
        chk("rst_fi", 65'(drain_fi), 65'd0);
        chk("rst_ovf", 65'(ovf), 65'd0);
        @(negedge clock);
        reset = 1'b1;

        // Basic: two tiles, consumer always ready
        out_rdy = 1'b1;
        start(2);
        for (int i = 0; i < 6; i++) send(w[i], 1'b1);
        end_send();
        exp_tail();
        wait_fi("basic_fi");
        chk("basic_fi_lat", 65'(cyc - last_pop_cyc), 65'd2);
        chk("basic_left", 65'(expq.size()), 65'd0);
        back_to_idle("basic_idle");

        // Overflow: 12 words into 8 entries with the consumer stalled
        out_rdy = 1'b0;
        start(4);
        for (int i = 0; i < 12; i++) send(w[i], i < 8);
        end_send();
        @(negedge clock);
        chk("ovf_flag", 65'(ovf), 65'd1);
        chk("ovf_vld", 65'(out_vld), 65'd1);
        chk("ovf_head", 65'(out_data), 65'(w[0]));
        chk("ovf_fi_early", 65'(drain_fi), 65'd0);
        @(posedge clock);
        #1;
        out_rdy = 1'b1;
        exp_tail();
        wait_fi("ovf_fi");
        chk("ovf_left", 65'(expq.size()), 65'd0);
        chk("ovf_sticky", 65'(ovf), 65'd1);
        back_to_idle("ovf_idle");

        // Backpressure: hold the head word stable while stalled
        out_rdy = 1'b0;
        start(1);
        for (int i = 0; i < 3; i++) send(w[i + 3], 1'b1);
        end_send();
        chk("bp_ovf_clr", 65'(ovf), 65'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_vld", 65'(out_vld), 65'd1);
            chk("bp_hold", {out_last, out_data}, {1'b0, w[3]});
        end
        @(posedge clock);
        #1;
        out_rdy = 1'b1;
        exp_tail();
        wait_fi("bp_fi");
        chk("bp_left", 65'(expq.size()), 65'd0);
        chk("bp_ovf", 65'(ovf), 65'd0);
        back_to_idle("bp_idle");

        // Zero tiles: straight to DONE, nothing emitted
        start(0);
        @(negedge clock);
        chk("zt_fi_pre", 65'(drain_fi), 65'd0);
        @(negedge clock);
        chk("zt_fi", 65'(drain_fi), 65'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("zt_vld", 65'(out_vld), 65'd0);
        end
        back_to_idle("zt_idle");

        // Async reset after two of three words
        out_rdy = 1'b0;
        start(1);
        send(w[9], 1'b0);
        send(w[10], 1'b0);
        end_send();
        @(negedge clock);
        chk("ar_vld_pre", 65'(out_vld), 65'd1);
        #2;
        reset = 1'b0;
        drain_en = 1'b0;
        #1;
        chk("ar_vld", 65'(out_vld), 65'd0);
        chk("ar_data", 65'(out_data), 65'd0);
        chk("ar_last", 65'(out_last), 65'd0);
        chk("ar_fi", 65'(drain_fi), 65'd0);
        expq.delete();
        @(negedge clock);
        reset = 1'b1;
        out_rdy = 1'b1;
        start(1);
        for (int i = 0; i < 3; i++) send(w[i + 6], 1'b1);
        end_send();
        exp_tail();
        wait_fi("ar_fi_done");
        chk("ar_left", 65'(expq.size()), 65'd0);
        back_to_idle("ar_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
